// File: rtl/nios2_qsys_dct_packer.sv
// DCT frame packer: shifts 2-bit trace codes into an accumulator and hands full or
// flushed frames to the trace sink through a single valid/ready output register.
module nios2_qsys_dct_packer #(
    parameter int CODE_W = 2,
    parameter int DEPTH  = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      code_valid,
    input  logic [CODE_W-1:0]         code,
    output logic                      code_ready,
    input  logic                      flush,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [CODE_W*DEPTH-1:0]   dct_buffer,
    output logic [3:0]                dct_count,
    output logic [15:0]               frame_count
);
    localparam int         BUF_W   = CODE_W * DEPTH;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    logic [BUF_W-1:0] acc_q, acc_d;
    logic [3:0]       acc_cnt_q, acc_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             frame_valid_q, frame_valid_d;
    logic [BUF_W-1:0] dct_buffer_q, dct_buffer_d;
    logic [3:0]       dct_count_q, dct_count_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic             accept;
    logic             consume;
    logic             complete;
    logic             slot_free;
    logic             xfer;
    logic [BUF_W-1:0] acc_nx;
    logic [3:0]       cnt_nx;

    assign code_ready = (acc_cnt_q < DEPTH_L) && !flush_pend_q;
    assign accept     = code_valid && code_ready;
    assign consume    = frame_valid_q && frame_ready;
    assign slot_free  = !frame_valid_q || frame_ready;

    // Newest code enters at the bottom, so the oldest ends up in the highest occupied bits.
    assign acc_nx = accept ? ((acc_q << CODE_W) | BUF_W'(code)) : acc_q;
    assign cnt_nx = accept ? (acc_cnt_q + 4'd1) : acc_cnt_q;

    assign complete = (cnt_nx == DEPTH_L) || ((flush || flush_pend_q) && (cnt_nx != 4'd0));
    assign xfer     = complete && slot_free;

    always_comb begin
        acc_d         = acc_nx;
        acc_cnt_d     = cnt_nx;
        flush_pend_d  = flush_pend_q;
        frame_valid_d = frame_valid_q;
        dct_buffer_d  = dct_buffer_q;
        dct_count_d   = dct_count_q;
        frame_count_d = frame_count_q;

        if (consume) begin
            frame_valid_d = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
        end

        if (xfer) begin
            // A new frame may replace the one being consumed on the same edge.
            dct_buffer_d  = acc_nx;
            dct_count_d   = cnt_nx;
            frame_valid_d = 1'b1;
            acc_d         = '0;
            acc_cnt_d     = 4'd0;
            flush_pend_d  = 1'b0;
        end else if (flush && (cnt_nx != 4'd0)) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q         <= '0;
            acc_cnt_q     <= 4'd0;
            flush_pend_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            dct_buffer_q  <= '0;
            dct_count_q   <= 4'd0;
            frame_count_q <= 16'd0;
        end else begin
            acc_q         <= acc_d;
            acc_cnt_q     <= acc_cnt_d;
            flush_pend_q  <= flush_pend_d;
            frame_valid_q <= frame_valid_d;
            dct_buffer_q  <= dct_buffer_d;
            dct_count_q   <= dct_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign dct_buffer  = dct_buffer_q;
    assign dct_count   = dct_count_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_nios2_qsys_dct_packer.sv
// Directed bench for the DCT packer: full frames, flushes, output stalls and reset.
module tb_nios2_qsys_dct_packer;
    logic        clk;
    logic        reset_n;
    logic        code_valid;
    logic [1:0]  code;
    logic        code_ready;
    logic        flush;
    logic        frame_valid;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [15:0] frame_count;

    int total;
    int bad;

    nios2_qsys_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .flush      (flush),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            code_valid = 1'b1;
            code       = c;
            tick();
        end
        code_valid = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        code_valid  = 1'b0;
        code        = 2'd0;
        flush       = 1'b0;
        frame_ready = 1'b0;
        tick();
        tick();
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_buf", 32'(dct_buffer), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_ready", 32'(code_ready), 32'd1);

        // T2: full frame of 2'b01
        frame_ready = 1'b1;
        send(2'b01, 15);
        chk("t2_fv", 32'(frame_valid), 32'd1);
        chk("t2_buf", 32'(dct_buffer), 32'h15555555);
        chk("t2_cnt", 32'(dct_count), 32'hF);
        chk("t2_fc0", 32'(frame_count), 32'd0);
        tick();
        chk("t2_fv_drop", 32'(frame_valid), 32'd0);
        chk("t2_fc1", 32'(frame_count), 32'd1);

        // T3: partial frame via flush
        code_valid = 1'b1; code = 2'd3; tick();
        code = 2'd2; tick();
        code = 2'd1; tick();
        code_valid = 1'b0;
        chk("t3_noframe", 32'(frame_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_fv", 32'(frame_valid), 32'd1);
        chk("t3_buf", 32'(dct_buffer), 32'h39);
        chk("t3_cnt", 32'(dct_count), 32'd3);
        tick();
        chk("t3_fv_drop", 32'(frame_valid), 32'd0);
        chk("t3_buf_hold", 32'(dct_buffer), 32'h39);
        chk("t3_fc", 32'(frame_count), 32'd2);

        // T4: stalled sink, second frame held in the accumulator
        frame_ready = 1'b0;
        send(2'b10, 30);
        chk("t4_fv", 32'(frame_valid), 32'd1);
        chk("t4_buf1", 32'(dct_buffer), 32'h2AAAAAAA);
        chk("t4_ready_lo", 32'(code_ready), 32'd0);
        chk("t4_fc_stall", 32'(frame_count), 32'd2);
        frame_ready = 1'b1;
        tick();
        chk("t4_fv_stay", 32'(frame_valid), 32'd1);
        chk("t4_buf2", 32'(dct_buffer), 32'h2AAAAAAA);
        chk("t4_cnt2", 32'(dct_count), 32'hF);
        chk("t4_fc1", 32'(frame_count), 32'd3);
        chk("t4_ready_hi", 32'(code_ready), 32'd1);
        tick();
        chk("t4_fv_drop", 32'(frame_valid), 32'd0);
        chk("t4_fc2", 32'(frame_count), 32'd4);

        // T5: flush on empty accumulator, then flush with a same-cycle code
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_empty_fv", 32'(frame_valid), 32'd0);
        tick();
        chk("t5_empty_fv2", 32'(frame_valid), 32'd0);
        chk("t5_no_pend", 32'(code_ready), 32'd1);
        flush = 1'b1; code_valid = 1'b1; code = 2'b11;
        tick();
        flush = 1'b0; code_valid = 1'b0;
        chk("t5_fv", 32'(frame_valid), 32'd1);
        chk("t5_buf", 32'(dct_buffer), 32'h3);
        chk("t5_cnt", 32'(dct_count), 32'd1);
        tick();
        chk("t5_fc", 32'(frame_count), 32'd5);

        // T6: flush while the output slot is stalled
        frame_ready = 1'b0;
        send(2'b01, 2);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t6_a_cnt", 32'(dct_count), 32'd2);
        send(2'b11, 5);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t6_pend_ready", 32'(code_ready), 32'd0);
        chk("t6_a_hold", 32'(dct_buffer), 32'h5);
        tick();
        chk("t6_pend_ready2", 32'(code_ready), 32'd0);
        chk("t6_a_cnt_hold", 32'(dct_count), 32'd2);
        frame_ready = 1'b1;
        tick();
        chk("t6_b_fv", 32'(frame_valid), 32'd1);
        chk("t6_b_buf", 32'(dct_buffer), 32'h3FF);
        chk("t6_b_cnt", 32'(dct_count), 32'd5);
        chk("t6_ready_back", 32'(code_ready), 32'd1);
        tick();
        chk("t6_fv_drop", 32'(frame_valid), 32'd0);
        chk("t6_fc", 32'(frame_count), 32'd7);

        // T1: reset mid-run with a held frame and a partial accumulator
        frame_ready = 1'b0;
        send(2'b10, 3);
        flush = 1'b1; tick(); flush = 1'b0;
        send(2'b01, 2);
        chk("t1_pre_fv", 32'(frame_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_fv", 32'(frame_valid), 32'd0);
        chk("t1_buf", 32'(dct_buffer), 32'd0);
        chk("t1_cnt", 32'(dct_count), 32'd0);
        chk("t1_fc", 32'(frame_count), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("t1_ready", 32'(code_ready), 32'd1);
        frame_ready = 1'b1;
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t1_discard", 32'(frame_valid), 32'd0);
        flush = 1'b1; code_valid = 1'b1; code = 2'b01;
        tick();
        flush = 1'b0; code_valid = 1'b0;
        chk("t1_fresh_buf", 32'(dct_buffer), 32'h1);
        chk("t1_fresh_cnt", 32'(dct_count), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
